prince_sbox_layer_ctrl: RTL
===========================

// Module: prince_sbox_layer_ctrl
// PURPOSE
// - Sequences one masked PRINCE S-box layer (16 nibbles, CMS-shared) through one shared pipelined S-box core.
// - Accepts a shared 64-bit state, issues one nibble per enabled cycle and gates the core pipeline on fresh-randomness availability.
// - Reassembles the shared result and returns it over a valid/ready handshake.
// - Sits between the PRINCE round FSM and the masked S-box datapath; the component-function modules (s_bitN_shM) live inside the core.
// PARAMETERS
// - SHARES    3   input/output share count of the core (shares after compression)
// - SBOX_LAT  2   core latency in enabled cycles (register stages inside the core, >=1)
// - RND_W     8   fresh-randomness bits the core consumes per issued nibble
// PORTS
// - clk          in   1           single clock, rising edge
// - rst_n        in   1           asynchronous, active-low reset
// - in_valid     in   1           state offered
// - in_ready     out  1           controller can accept (IDLE)
// - in_state     in   SHARES*64   share s at [s*64+:64]; nibble k of a share at [4k+:4], bit3=x, bit2=y, bit1=z, bit0=w
// - in_inv       in   1           1 = inverse S-box, sampled with in_state
// - out_valid    out  1           result held
// - out_ready    in   1           consumer takes result
// - out_state    out  SHARES*64   shared S-box layer output, same packing as in_state
// - rnd_req      out  1           controller wants RND_W fresh bits this cycle
// - rnd_valid    in   1           fresh bits present on core rnd input (PRNG drives core directly)
// - sb_en        out  1           advance core pipeline
// - sb_inv       out  1           inverse select to core, constant for whole layer
// - sb_din       out  SHARES*4    nibble k of every share, share s at [s*4+:4]
// - sb_dout      in   SHARES*4    core output, same packing
// - busy         out  1           state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1; out_valid=0; out_state=0; sb_en=0; rnd_req=0; sb_din=0; sb_inv=0; counters=0.
// - FSM IDLE -> ISSUE on in_valid&&in_ready: latch in_state/in_inv, iss_cnt=0, ret_cnt=0.
// - ISSUE: rnd_req=1; sb_din=latched nibble iss_cnt; sb_en=rnd_valid. Each sb_en cycle: iss_cnt++.
// - ISSUE -> DRAIN after the sb_en cycle with iss_cnt==15.
// - rnd_valid low in ISSUE freezes the whole pipeline (sb_en=0): no issue, no retire, all counters held.
// - DRAIN: rnd_req=0; sb_en=1 every cycle; sb_din=0 (bubble; core masks unused).
// - Retire: a nibble issued on enabled cycle t is valid on sb_dout in the same cycle as enabled cycle t+SBOX_LAT.
//   - On each sb_en cycle with SBOX_LAT issued-but-unretired nibbles in flight, write sb_dout into out_state nibble ret_cnt, then ret_cnt++.
// - DRAIN -> DONE after the retire of nibble 15. DONE: out_valid=1, out_state stable, sb_en=0.
// - DONE -> IDLE on out_ready. in_ready stays low in DONE, so there is no back-to-back overlap.
// - Latency with rnd_valid held high: accept at cycle 0, out_valid at cycle 16+SBOX_LAT+1. Each rnd_valid-low cycle in ISSUE adds 1.
// - out_state is written only during retire; it keeps the previous result until overwritten nibble by nibble, and the consumer uses it only while out_valid.
// - Counters are 4-bit plus a 2-state done flag. iss_cnt never wraps past 15 inside ISSUE.
// - Simultaneous in_valid and out_ready in DONE: only the output handshake completes; input accepted next cycle in IDLE.
// - sb_inv must never change while busy. in_inv is ignored outside IDLE.
// - Reset mid-layer: immediate return to IDLE, in-flight nibbles discarded, out_valid=0. The core is reset by the same rst_n.
// - Security: no share combination inside the controller; per-share muxes only, never XOR across shares.
// STRUCTURE
// - Package prince_masked_pkg:
//   - SHARES and NIBBLES=16 constants
//   - typedef shared_state_t = logic [SHARES-1:0][63:0]
//   - typedef shared_nib_t = logic [SHARES-1:0][3:0]
//   - enum layer_st_e {IDLE, ISSUE, DRAIN, DONE}
// - One sub-module, prince_nib_lane: per-share 16:1 nibble select for issue and a 1:16 write-enable decode for retire, instantiated SHARES times.
// - Core instantiated by the parent, not here.
// TESTING
// - Reset then idle: rst_n low mid-ISSUE -> all outputs at reset values within 0 clocks; in_ready=1 on first edge after release.
// - Known vector: share0=0x0123456789ABCDEF, other shares 0, in_inv=0, rnd_valid=1 -> unshared XOR of out_state = PRINCE S(x) per nibble (nibble0 S(0xF)=0x4); out_valid at cycle 16+SBOX_LAT+1.
// - Inverse: feed the previous result with in_inv=1 -> unshared output 0x0123456789ABCDEF; sb_inv=1 throughout busy.
// - Randomness stall: rnd_valid low for 5 cycles at iss_cnt=7 -> sb_en=0 those cycles, no out_state writes, result unchanged, latency +5.
// - Backpressure: out_ready low for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0, new in_valid ignored until release.
// - Random shared inputs (SHARES=3, SBOX_LAT=1 and 3) against a golden model, 1000 layers -> XOR of shares matches S/S^-1 every nibble.

Source files
------------

// File: rtl/prince_masked_pkg.sv
// Shared types and constants for the masked PRINCE S-box layer controller.
// A shared 64-bit state is carried as SHARES packed words; nibble k of share s sits at [s][4k+:4].
package prince_masked_pkg;

    localparam int SHARES  = 3;
    localparam int NIBBLES = 16;

    typedef logic [SHARES-1:0][63:0] shared_state_t;
    typedef logic [SHARES-1:0][3:0]  shared_nib_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } layer_st_e;

endpackage

// File: rtl/prince_nib_lane.sv
// One share lane of the layer controller.
// Selects the nibble to issue and decodes the nibble slot written on retire.
module prince_nib_lane (
    input  logic [63:0] i_word,
    input  logic [3:0]  i_sel,
    output logic [3:0]  o_nib,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_idx,
    output logic [15:0] o_wr_mask
);

    assign o_nib = i_word[{i_sel, 2'b00} +: 4];

    always_comb begin
        o_wr_mask = '0;
        if (i_wr_en) begin
            o_wr_mask[i_wr_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/prince_sbox_layer_ctrl.sv
// Sequences one CMS-shared PRINCE S-box layer through a shared pipelined S-box core.
// Shares stay in separate lanes end to end; the controller only muxes, it never combines shares.
module prince_sbox_layer_ctrl
    import prince_masked_pkg::*;
#(
    parameter int SBOX_LAT = 2,
    parameter int RND_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SHARES*64-1:0] in_state,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SHARES*64-1:0] out_state,
    output logic                 rnd_req,
    input  logic                 rnd_valid,
    output logic                 sb_en,
    output logic                 sb_inv,
    output logic [SHARES*4-1:0]  sb_din,
    input  logic [SHARES*4-1:0]  sb_dout,
    output logic                 busy
);

    localparam int FILL_W = $clog2(SBOX_LAT + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SBOX_LAT);

    // RND_W is consumed by the core straight from the PRNG; the controller only requests it.
    if (RND_W < 1) begin : g_rnd_w_unused
    end

    layer_st_e         r_st;
    layer_st_e         w_st_nxt;
    shared_state_t     r_in;
    shared_state_t     r_out;
    logic              r_inv;
    logic [3:0]        r_iss_cnt;
    logic [3:0]        r_ret_cnt;
    logic [FILL_W-1:0] r_fill;
    logic              w_accept;
    logic              w_sb_en;
    logic              w_retire;
    shared_nib_t       w_lane_nib;
    shared_nib_t       w_dout;
    logic [15:0]       w_wr_mask [SHARES];

    assign w_accept = (r_st == IDLE) && in_valid;
    assign w_dout   = sb_dout;
    // r_fill counts enabled cycles up to SBOX_LAT; once full, every enabled cycle retires a nibble.
    assign w_retire = w_sb_en && (r_fill == FILL_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        unique case (r_st)
            IDLE:    if (in_valid)                            w_st_nxt = ISSUE;
            ISSUE:   if (w_sb_en && (r_iss_cnt == 4'd15))     w_st_nxt = DRAIN;
            DRAIN:   if (w_retire && (r_ret_cnt == 4'd15))    w_st_nxt = DONE;
            DONE:    if (out_ready)                           w_st_nxt = IDLE;
            default:                                          w_st_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rnd_req   = 1'b0;
        w_sb_en   = 1'b0;
        unique case (r_st)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ISSUE: begin
                rnd_req = 1'b1;
                w_sb_en = rnd_valid;
            end
            DRAIN:   w_sb_en   = 1'b1;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    assign sb_en     = w_sb_en;
    assign sb_inv    = r_inv;
    assign sb_din    = (r_st == ISSUE) ? w_lane_nib : '0;
    assign out_state = r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in      <= '0;
            r_inv     <= 1'b0;
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_fill    <= '0;
        end else if (w_accept) begin
            r_in      <= in_state;
            r_inv     <= in_inv;
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_fill    <= '0;
        end else begin
            if (w_sb_en && (r_st == ISSUE) && (r_iss_cnt != 4'd15)) begin
                r_iss_cnt <= r_iss_cnt + 4'd1;
            end
            if (w_sb_en && (r_fill != FILL_FULL)) begin
                r_fill <= r_fill + FILL_W'(1);
            end
            if (w_retire && (r_ret_cnt != 4'd15)) begin
                r_ret_cnt <= r_ret_cnt + 4'd1;
            end
        end
    end

    for (genvar s = 0; s < SHARES; s++) begin : g_lane
        prince_nib_lane u_lane (
            .i_word    (r_in[s]),
            .i_sel     (r_iss_cnt),
            .o_nib     (w_lane_nib[s]),
            .i_wr_en   (w_retire),
            .i_wr_idx  (r_ret_cnt),
            .o_wr_mask (w_wr_mask[s])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            for (int s = 0; s < SHARES; s++) begin
                for (int k = 0; k < NIBBLES; k++) begin
                    if (w_wr_mask[s][k]) begin
                        r_out[s][4*k +: 4] <= w_dout[s];
                    end
                end
            end
        end
    end

endmodule
